// File: rtl/fifo_check_pkg.sv
// rtl/fifo_check_pkg.sv - shared state encoding and channel indices for the FIFO check-statistics block
package fifo_check_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} chk_state_e;

    localparam int CHK_DATA_OUT     = 0;
    localparam int CHK_ACK          = 1;
    localparam int CHK_OVERFLOW     = 2;
    localparam int CHK_FULL         = 3;
    localparam int CHK_EMPTY        = 4;
    localparam int CHK_ALMOST_FULL  = 5;
    localparam int CHK_ALMOST_EMPTY = 6;
    localparam int CHK_UNDERFLOW    = 7;
    localparam int NUM_CHK_DEFAULT  = 8;

endpackage

// File: rtl/fifo_sat_counter.sv
// rtl/fifo_sat_counter.sv - saturating up-counter with synchronous clear
module fifo_sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fifo_check_counters.sv
// rtl/fifo_check_counters.sv - per-channel pass/fail statistics, error total, run-cycle count and first-error capture
module fifo_check_counters
    import fifo_check_pkg::*;
#(
    parameter  int NUM_CHK = NUM_CHK_DEFAULT,
    parameter  int CNT_W   = 32,
    localparam int IDX_W   = $clog2(NUM_CHK) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_start,
    input  logic               i_finish,
    input  logic [NUM_CHK-1:0] i_chk_valid,
    input  logic [NUM_CHK-1:0] i_chk_pass,
    input  logic [IDX_W-1:0]   i_rd_idx,
    output logic [CNT_W-1:0]   o_rd_err,
    output logic [CNT_W-1:0]   o_rd_corr,
    output logic [CNT_W-1:0]   o_total_err,
    output logic [CNT_W-1:0]   o_cycle_cnt,
    output logic               o_any_err,
    output logic [IDX_W-1:0]   o_first_err_idx,
    output logic [CNT_W-1:0]   o_first_err_cycle,
    output logic               o_busy,
    output logic               o_done
);

    chk_state_e         r_state;
    chk_state_e         w_state_nxt;
    logic               w_run;
    logic [NUM_CHK-1:0] w_fail;
    logic [NUM_CHK-1:0] w_good;
    logic [CNT_W-1:0]   w_err  [NUM_CHK];
    logic [CNT_W-1:0]   w_corr [NUM_CHK];
    logic [CNT_W-1:0]   w_cycle;
    logic [CNT_W:0]     w_fail_cnt;
    logic [CNT_W:0]     w_total_sum;
    logic [CNT_W-1:0]   w_total_nxt;
    logic [IDX_W-1:0]   w_low_idx;
    logic [CNT_W-1:0]   w_sel_err;
    logic [CNT_W-1:0]   w_sel_corr;

    logic [CNT_W-1:0]   r_total;
    logic               r_any;
    logic [IDX_W-1:0]   r_first_idx;
    logic [CNT_W-1:0]   r_first_cycle;
    logic [CNT_W-1:0]   r_rd_err;
    logic [CNT_W-1:0]   r_rd_corr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start)  w_state_nxt = ST_RUN;
                ST_RUN:  if (i_finish) w_state_nxt = ST_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // The finish cycle is still a RUN cycle, so its results are counted.
    assign w_run  = (r_state == ST_RUN) && !i_clr;
    assign w_fail = i_chk_valid & ~i_chk_pass;
    assign w_good = i_chk_valid & i_chk_pass;

    for (genvar g = 0; g < NUM_CHK; g++) begin : g_chan
        fifo_sat_counter #(.W(CNT_W)) u_err (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_clr (i_clr),
            .i_inc (w_run && w_fail[g]),
            .o_cnt (w_err[g])
        );
        fifo_sat_counter #(.W(CNT_W)) u_corr (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_clr (i_clr),
            .i_inc (w_run && w_good[g]),
            .o_cnt (w_corr[g])
        );
    end

    fifo_sat_counter #(.W(CNT_W)) u_cycle (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr),
        .i_inc (w_run),
        .o_cnt (w_cycle)
    );

    always_comb begin
        w_fail_cnt = '0;
        w_low_idx  = '0;
        for (int i = 0; i < NUM_CHK; i++) begin
            w_fail_cnt = w_fail_cnt + (CNT_W+1)'(w_fail[i]);
        end
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (w_fail[i]) w_low_idx = IDX_W'(i);
        end
        // Extra carry bit lets the total clamp instead of wrapping.
        w_total_sum = {1'b0, r_total} + w_fail_cnt;
        w_total_nxt = w_total_sum[CNT_W] ? '1 : w_total_sum[CNT_W-1:0];
    end

    always_comb begin
        w_sel_err  = '0;
        w_sel_corr = '0;
        for (int i = 0; i < NUM_CHK; i++) begin
            if (i_rd_idx == IDX_W'(i)) begin
                w_sel_err  = w_err[i];
                w_sel_corr = w_corr[i];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_total       <= '0;
            r_any         <= 1'b0;
            r_first_idx   <= '0;
            r_first_cycle <= '0;
            r_rd_err      <= '0;
            r_rd_corr     <= '0;
        end else if (i_clr) begin
            r_total       <= '0;
            r_any         <= 1'b0;
            r_first_idx   <= '0;
            r_first_cycle <= '0;
            r_rd_err      <= '0;
            r_rd_corr     <= '0;
        end else begin
            r_rd_err  <= w_sel_err;
            r_rd_corr <= w_sel_corr;
            if (w_run) begin
                r_total <= w_total_nxt;
                if ((|w_fail) && !r_any) begin
                    r_any         <= 1'b1;
                    r_first_idx   <= w_low_idx;
                    r_first_cycle <= w_cycle;
                end
            end
        end
    end

    assign o_rd_err          = r_rd_err;
    assign o_rd_corr         = r_rd_corr;
    assign o_total_err       = r_total;
    assign o_cycle_cnt       = w_cycle;
    assign o_any_err         = r_any;
    assign o_first_err_idx   = r_first_idx;
    assign o_first_err_cycle = r_first_cycle;
    assign o_busy            = (r_state == ST_RUN);
    assign o_done            = (r_state == ST_DONE);

endmodule

// File: tb/tb_fifo_check_counters.sv
// tb/tb_fifo_check_counters.sv - bench for fifo_check_counters with 32-bit and 4-bit counter instances
module tb_fifo_check_counters;

    localparam int     NCH  = 8;
    localparam longint MAXA = (64'd1 << 32) - 1;
    localparam longint MAXB = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       finish = 1'b0;
    logic [7:0] chk_valid = '0;
    logic [7:0] chk_pass = '0;
    logic [3:0] rd_idx = '0;

    logic [31:0] a_rd_err, a_rd_corr, a_total, a_cycle, a_fcyc;
    logic [3:0]  a_fidx;
    logic        a_any, a_busy, a_done;
    logic [3:0]  b_rd_err, b_rd_corr, b_total, b_cycle, b_fcyc;
    logic [3:0]  b_fidx;
    logic        b_any, b_busy, b_done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    fifo_check_counters #(.NUM_CHK(NCH), .CNT_W(32)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_start(start), .i_finish(finish),
        .i_chk_valid(chk_valid), .i_chk_pass(chk_pass), .i_rd_idx(rd_idx),
        .o_rd_err(a_rd_err), .o_rd_corr(a_rd_corr), .o_total_err(a_total),
        .o_cycle_cnt(a_cycle), .o_any_err(a_any), .o_first_err_idx(a_fidx),
        .o_first_err_cycle(a_fcyc), .o_busy(a_busy), .o_done(a_done)
    );

    fifo_check_counters #(.NUM_CHK(NCH), .CNT_W(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_start(start), .i_finish(finish),
        .i_chk_valid(chk_valid), .i_chk_pass(chk_pass), .i_rd_idx(rd_idx),
        .o_rd_err(b_rd_err), .o_rd_corr(b_rd_corr), .o_total_err(b_total),
        .o_cycle_cnt(b_cycle), .o_any_err(b_any), .o_first_err_idx(b_fidx),
        .o_first_err_cycle(b_fcyc), .o_busy(b_busy), .o_done(b_done)
    );

    // Reference model: index 0 models the 32-bit instance, index 1 the 4-bit one.
    longint m_err [2][NCH];
    longint m_corr[2][NCH];
    longint m_total[2], m_cyc[2], m_fcyc[2], m_fidx[2], m_rd_err[2], m_rd_corr[2];
    bit     m_any[2];
    int     m_state;   // 0 idle, 1 running, 2 finished

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_zero(input int k);
        for (int i = 0; i < NCH; i++) begin
            m_err[k][i]  = 0;
            m_corr[k][i] = 0;
        end
        m_total[k] = 0; m_cyc[k] = 0; m_fcyc[k] = 0; m_fidx[k] = 0;
        m_rd_err[k] = 0; m_rd_corr[k] = 0; m_any[k] = 1'b0;
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            longint mx;
            int nf, low;
            mx = (k == 0) ? MAXA : MAXB;
            if (clr) begin
                model_zero(k);
            end else begin
                m_rd_err[k]  = (rd_idx < NCH) ? m_err[k][int'(rd_idx)]  : 0;
                m_rd_corr[k] = (rd_idx < NCH) ? m_corr[k][int'(rd_idx)] : 0;
                if (m_state == 1) begin
                    nf = 0; low = -1;
                    for (int i = 0; i < NCH; i++) begin
                        if (chk_valid[i]) begin
                            if (chk_pass[i]) m_corr[k][i] = sat(m_corr[k][i] + 1, mx);
                            else begin
                                m_err[k][i] = sat(m_err[k][i] + 1, mx);
                                nf++;
                                if (low < 0) low = i;
                            end
                        end
                    end
                    m_total[k] = sat(m_total[k] + nf, mx);
                    if (nf > 0 && !m_any[k]) begin
                        m_any[k] = 1'b1; m_fidx[k] = low; m_fcyc[k] = m_cyc[k];
                    end
                    m_cyc[k] = sat(m_cyc[k] + 1, mx);
                end
            end
        end
        if (clr) m_state = 0;
        else if (m_state == 0 && start) m_state = 1;
        else if (m_state == 1 && finish) m_state = 2;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_zero(0); model_zero(1); m_state = 0;
        end else begin
            model_step();
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("a_rd_err",  {32'b0, a_rd_err},  m_rd_err[0]);
            check("a_rd_corr", {32'b0, a_rd_corr}, m_rd_corr[0]);
            check("a_total",   {32'b0, a_total},   m_total[0]);
            check("a_cycle",   {32'b0, a_cycle},   m_cyc[0]);
            check("a_any",     {63'b0, a_any},     {63'b0, m_any[0]});
            check("a_fidx",    {60'b0, a_fidx},    m_fidx[0]);
            check("a_fcyc",    {32'b0, a_fcyc},    m_fcyc[0]);
            check("a_busy",    {63'b0, a_busy},    {63'b0, m_state == 1});
            check("a_done",    {63'b0, a_done},    {63'b0, m_state == 2});
            check("b_rd_err",  {60'b0, b_rd_err},  m_rd_err[1]);
            check("b_rd_corr", {60'b0, b_rd_corr}, m_rd_corr[1]);
            check("b_total",   {60'b0, b_total},   m_total[1]);
            check("b_cycle",   {60'b0, b_cycle},   m_cyc[1]);
            check("b_any",     {63'b0, b_any},     {63'b0, m_any[1]});
            check("b_fidx",    {60'b0, b_fidx},    m_fidx[1]);
            check("b_fcyc",    {60'b0, b_fcyc},    m_fcyc[1]);
            check("b_busy",    {63'b0, b_busy},    {63'b0, m_state == 1});
            check("b_done",    {63'b0, b_done},    {63'b0, m_state == 2});
        end
    end

    task automatic drive(input bit s, input bit f, input bit c,
                         input logic [7:0] v, input logic [7:0] p, input logic [3:0] idx);
        start = s; finish = f; clr = c; chk_valid = v; chk_pass = p; rd_idx = idx;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_total", {32'b0, a_total}, 0);
        check("rst_cycle", {32'b0, a_cycle}, 0);
        check("rst_any",   {63'b0, a_any},   0);
        check("rst_busy",  {63'b0, a_busy},  0);
        check("rst_done",  {63'b0, a_done},  0);
        check("rst_rd",    {32'b0, a_rd_err}, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        drive(1, 0, 0, 8'h00, 8'h00, 4'd0);
        repeat (5) drive(0, 0, 0, 8'hFF, 8'hFF, 4'd0);
        check("t2_cycle", {32'b0, a_cycle}, 5);
        check("t2_any",   {63'b0, a_any},   0);
        drive(0, 1, 0, 8'h00, 8'h00, 4'd0);
        for (int i = 0; i < NCH; i++) begin
            drive(0, 0, 0, 8'h00, 8'h00, 4'(i));
            check("t2_rd_corr", {32'b0, a_rd_corr}, 5);
            check("t2_rd_err",  {32'b0, a_rd_err},  0);
        end

        drive(0, 0, 1, 8'h00, 8'h00, 4'd0);
        drive(1, 0, 0, 8'h00, 8'h00, 4'd0);
        for (int r = 0; r < 6; r++)
            drive(0, 0, 0, 8'hFF, (r == 2) ? 8'hF5 : ((r == 4) ? 8'hFE : 8'hFF), 4'd0);
        drive(0, 1, 0, 8'h00, 8'h00, 4'd0);
        check("t3_fidx",  {60'b0, a_fidx},  1);
        check("t3_fcyc",  {32'b0, a_fcyc},  2);
        check("t3_total", {32'b0, a_total}, 3);
        drive(0, 0, 0, 8'h00, 8'h00, 4'd1);
        check("t3_err1", {32'b0, a_rd_err}, 1);
        drive(0, 0, 0, 8'h00, 8'h00, 4'd3);
        check("t3_err3", {32'b0, a_rd_err}, 1);
        drive(0, 0, 0, 8'h00, 8'h00, 4'd0);
        check("t3_err0", {32'b0, a_rd_err}, 1);

        drive(0, 0, 1, 8'h00, 8'h00, 4'd0);
        drive(1, 0, 0, 8'h00, 8'h00, 4'd0);
        repeat (20) drive(0, 0, 0, 8'h01, 8'h01, 4'd0);
        drive(0, 1, 0, 8'h00, 8'h00, 4'd0);
        drive(0, 0, 0, 8'h00, 8'h00, 4'd0);
        check("t4_b_corr0", {60'b0, b_rd_corr}, 15);
        check("t4_b_cycle", {60'b0, b_cycle},   15);
        check("t4_a_corr0", {32'b0, a_rd_corr}, 20);
        check("t4_a_cycle", {32'b0, a_cycle},   21);

        drive(0, 0, 1, 8'h00, 8'h00, 4'd0);
        drive(1, 0, 0, 8'h00, 8'h00, 4'd0);
        repeat (3) drive(0, 0, 0, 8'hFF, 8'hFF, 4'd0);
        drive(0, 1, 0, 8'h04, 8'h00, 4'd2);
        check("t5_done", {63'b0, a_done}, 1);
        drive(0, 0, 0, 8'h00, 8'h00, 4'd2);
        check("t5_err2", {32'b0, a_rd_err}, 1);
        repeat (3) drive(0, 0, 0, 8'hFF, 8'h00, 4'd2);
        check("t5_err2_frozen", {32'b0, a_rd_err}, 1);
        check("t5_total_frozen", {32'b0, a_total}, 1);
        drive(1, 0, 0, 8'h00, 8'h00, 4'd2);
        check("t6_start_in_done", {63'b0, a_done}, 1);
        check("t6_busy_in_done",  {63'b0, a_busy}, 0);
        drive(0, 0, 0, 8'h00, 8'h00, 4'd9);
        check("t6_idx9_err",  {32'b0, a_rd_err},  0);
        check("t6_idx9_corr", {32'b0, a_rd_corr}, 0);
        drive(0, 0, 1, 8'h00, 8'h00, 4'd0);
        check("t5_clr_corr0", {32'b0, a_rd_corr}, 0);
        check("t5_clr_any",   {63'b0, a_any},      0);
        check("t5_clr_total", {32'b0, a_total},    0);
        check("t5_clr_done",  {63'b0, a_done},     0);

        drive(1, 0, 0, 8'h00, 8'h00, 4'd0);
        repeat (4) drive(0, 0, 0, 8'hFF, 8'hF0, 4'd0);
        check("t6_pre_rst_cycle", {32'b0, a_cycle}, 4);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_cycle", {32'b0, a_cycle},  0);
        check("t6_rst_total", {32'b0, a_total},  0);
        check("t6_rst_any",   {63'b0, a_any},    0);
        check("t6_rst_busy",  {63'b0, a_busy},   0);
        check("t6_rst_rd",    {32'b0, a_rd_corr}, 0);
        @(negedge clk);
        rst = 1'b0;

        repeat (1500) begin
            drive(($urandom % 8) == 0, ($urandom % 24) == 0, ($urandom % 100) == 0,
                  8'($urandom), 8'($urandom | $urandom), 4'($urandom % 16));
        end
        drive(0, 0, 0, 8'h00, 8'h00, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
